correct_dc_values: RTL

//  Chroma DC error-diffusion quantiser, the stage directly upstream of the diffusion-error store.
//  Per macroblock it reads the top-error word for column x and adds top/left diffusion corrections
//  to the 8 U/V DC coefficients. It then quantises each DC serially and emits the packed 48-bit derr

---
 rtl/cdv_pkg.sv | 46 ++++
 rtl/correct_dc_values_dc_quant_single.sv | 59 +++++
 rtl/correct_dc_values.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/cdv_pkg.sv
// Shared constants, FSM encoding and arithmetic helpers for the chroma DC
// error-diffusion quantiser.
package cdv_pkg;
    localparam int C1         = 7;
    localparam int C2         = 8;
    localparam int DSH        = 3;
    localparam int QFIX       = 17;
    localparam int DSCALE     = 1;
    localparam int NBLK       = 8;
    localparam int DC_W       = 16;
    localparam int ERR_W      = 8;
    localparam int DERR_LANES = 6;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD,
        ST_LAT,
        ST_ADD,
        ST_MUL,
        ST_QNT,
        ST_DONE
    } state_t;

    // Left/top words carry byte lane (2*ch + idx): {ch1.1, ch1.0, ch0.1, ch0.0}.
    function automatic logic signed [ERR_W-1:0] lt_lane(
        input logic [31:0] w,
        input logic        ch,
        input logic        idx
    );
        return w[{ch, idx, 3'b000} +: ERR_W];
    endfunction

    // Floor-weighted blend of a top and a left error: (7*T + 8*L) >>> 3.
    function automatic logic signed [DC_W-1:0] diffuse(
        input logic signed [ERR_W-1:0] t,
        input logic signed [ERR_W-1:0] l
    );
        logic signed [DC_W-1:0] tw;
        logic signed [DC_W-1:0] lw;
        logic signed [DC_W-1:0] acc;
        tw  = {{(DC_W-ERR_W){t[ERR_W-1]}}, t};
        lw  = {{(DC_W-ERR_W){l[ERR_W-1]}}, l};
        acc = tw * 16'(C1) + lw * 16'(C2);
        return acc >>> DSH;
    endfunction
endpackage

// File: rtl/correct_dc_values_dc_quant_single.sv
// Single-DC quantiser: the MUL cycle registers the reciprocal-scaled level of |c|,
// the QNT cycle rescales by q and forms the halved diffusion error.
module dc_quant_single
    import cdv_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    mul_en,
    input  logic signed [DC_W-1:0]  c,
    input  logic [15:0]             q,
    input  logic [15:0]             iq,
    input  logic [31:0]             bias,
    input  logic [31:0]             zthresh,
    output logic signed [DC_W-1:0]  out,
    output logic signed [ERR_W-1:0] e
);
    logic [15:0]            mag;
    logic                   sign_reg;
    logic                   nz_reg;
    logic [15:0]            mag_reg;
    logic [15:0]            lev_reg;
    logic signed [DC_W-1:0] c_reg;
    logic [15:0]            qv;
    logic [15:0]            resid;
    logic signed [DC_W-1:0] err_full;

    // |-32768| stays 0x8000, read as unsigned 32768.
    assign mag = c[15] ? (16'd0 - $unsigned(c)) : $unsigned(c);

    always_ff @(posedge clk) begin
        if (rst) begin
            sign_reg <= 1'b0;
            nz_reg   <= 1'b0;
            mag_reg  <= '0;
            lev_reg  <= '0;
            c_reg    <= '0;
        end else if (mul_en) begin
            sign_reg <= c[15];
            nz_reg   <= {16'd0, mag} > zthresh;
            mag_reg  <= mag;
            lev_reg  <= 16'((33'(mag) * 33'(iq) + 33'(bias)) >> QFIX);
            c_reg    <= c;
        end
    end

    always_comb begin
        out      = '0;
        err_full = '0;
        qv       = lev_reg * q;
        resid    = mag_reg - qv;
        if (nz_reg) begin
            out      = sign_reg ? $signed(16'd0 - qv) : $signed(qv);
            err_full = sign_reg ? $signed(16'd0 - resid) : $signed(resid);
        end else begin
            err_full = c_reg;
        end
        e = ERR_W'(err_full >>> DSCALE);
    end
endmodule

// File: rtl/correct_dc_values.sv
// Chroma DC error-diffusion quantiser: fetches the top-error word for column x, applies
// top/left diffusion to the eight U/V DCs and quantises them one block at a time.
module correct_dc_values
    import cdv_pkg::*;
#(
    parameter int XW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x,
    input  logic [31:0]   left_derr,
    input  logic [127:0]  dc_in,
    input  logic [15:0]   q,
    input  logic [15:0]   iq,
    input  logic [31:0]   bias,
    input  logic [31:0]   zthresh,
    output logic          top_derr_en,
    output logic [XW-1:0] top_derr_addr,
    input  logic [31:0]   top_derr_rd,
    output logic [127:0]  dc_out,
    output logic [47:0]   derr,
    output logic          busy,
    output logic          done
);
    state_t                  state_reg;
    state_t                  state_next;
    logic [2:0]              blk_reg;
    logic [XW-1:0]           addr_reg;
    logic [31:0]             left_reg;
    logic [31:0]             top_reg;
    logic [127:0]            dc_reg;
    logic [15:0]             q_reg;
    logic [15:0]             iq_reg;
    logic [31:0]             bias_reg;
    logic [31:0]             zthresh_reg;
    logic signed [DC_W-1:0]  c_reg;
    logic signed [DC_W-1:0]  c_next;
    logic signed [DC_W-1:0]  dc_cur;
    logic signed [ERR_W-1:0] t_sel;
    logic signed [ERR_W-1:0] l_sel;
    logic signed [DC_W-1:0]  q_out;
    logic signed [ERR_W-1:0] q_e;
    logic signed [DC_W-1:0]  res_dc [NBLK];
    logic signed [ERR_W-1:0] res_e  [NBLK];
    logic                    ch;

    assign ch            = blk_reg[2];
    assign top_derr_en   = (state_reg == ST_RD);
    assign top_derr_addr = addr_reg;
    assign busy          = (state_reg != ST_IDLE);
    assign done          = (state_reg == ST_DONE);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (start) state_next = ST_RD;
            ST_RD:   state_next = ST_LAT;
            ST_LAT:  state_next = ST_ADD;
            ST_ADD:  state_next = ST_MUL;
            ST_MUL:  state_next = ST_QNT;
            ST_QNT:  state_next = (blk_reg == 3'(NBLK - 1)) ? ST_DONE : ST_ADD;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Block b of a channel blends neighbours already known at this point in the raster:
    // stored top/left errors at the edges, freshly computed errors inside the 2x2.
    always_comb begin
        t_sel = '0;
        l_sel = '0;
        case (blk_reg[1:0])
            2'd0: begin
                t_sel = lt_lane(top_reg, ch, 1'b0);
                l_sel = lt_lane(left_reg, ch, 1'b0);
            end
            2'd1: begin
                t_sel = lt_lane(top_reg, ch, 1'b1);
                l_sel = res_e[{ch, 2'd0}];
            end
            2'd2: begin
                t_sel = res_e[{ch, 2'd0}];
                l_sel = lt_lane(left_reg, ch, 1'b1);
            end
            default: begin
                t_sel = res_e[{ch, 2'd1}];
                l_sel = res_e[{ch, 2'd2}];
            end
        endcase
        dc_cur = dc_reg[{blk_reg, 4'b0000} +: DC_W];
        c_next = dc_cur + diffuse(t_sel, l_sel);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= ST_IDLE;
            blk_reg     <= '0;
            addr_reg    <= '0;
            left_reg    <= '0;
            top_reg     <= '0;
            dc_reg      <= '0;
            q_reg       <= '0;
            iq_reg      <= '0;
            bias_reg    <= '0;
            zthresh_reg <= '0;
            c_reg       <= '0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                ST_IDLE: if (start) begin
                    blk_reg     <= '0;
                    addr_reg    <= x;
                    left_reg    <= left_derr;
                    dc_reg      <= dc_in;
                    q_reg       <= q;
                    iq_reg      <= iq;
                    bias_reg    <= bias;
                    zthresh_reg <= zthresh;
                end
                ST_LAT:  top_reg <= top_derr_rd;
                ST_ADD:  c_reg   <= c_next;
                ST_QNT:  blk_reg <= blk_reg + 3'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NBLK; i++) begin
                res_dc[i] <= '0;
                res_e[i]  <= '0;
            end
        end else if (state_reg == ST_QNT) begin
            res_dc[blk_reg] <= q_out;
            res_e[blk_reg]  <= q_e;
        end
    end

    dc_quant_single u_quant (
        .clk     (clk),
        .rst     (rst),
        .mul_en  (state_reg == ST_MUL),
        .c       (c_reg),
        .q       (q_reg),
        .iq      (iq_reg),
        .bias    (bias_reg),
        .zthresh (zthresh_reg),
        .out     (q_out),
        .e       (q_e)
    );

    // e0 of each channel stays internal; derr exposes e1..e3 per channel.
    genvar gi;
    generate
        for (gi = 0; gi < NBLK; gi++) begin : g_dc_pack
            assign dc_out[DC_W*gi +: DC_W] = res_dc[gi];
        end
        for (gi = 0; gi < DERR_LANES; gi++) begin : g_derr_pack
            localparam int SRC = 4 * (gi / 3) + (gi % 3) + 1;
            assign derr[ERR_W*gi +: ERR_W] = res_e[SRC];
        end
    endgenerate
endmodule
